cpu_run_ctrl: RTL and testbench

//   Synthesizable run controller for the CPU.
//   - Holds cpu_top in reset for a programmable number of cycles, then lets it run.
//   - Ends the run on one of three events: an explicit halt request, a PC stall
//     (a `j .` self-loop), or a cycle-budget timeout.
//   - Reports done, pass/timeout status, halt PC and cycle count. Used in both

---
 rtl/cpu_run_ctrl_if.sv | 35 +++
 rtl/cpu_run_ctrl.sv | 133 +++++++++++++
 tb/tb_cpu_run_ctrl.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/cpu_run_ctrl_if.sv
// Core-facing signal bundle for cpu_run_ctrl.
// instret exists only when RUN_CTRL_INSTRET_EN is defined.
interface cpu_run_ctrl_if #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned CNT_W = 32
);
    logic [XLEN-1:0]  pc;
    logic             halt_req;
    logic             commit;
    logic             core_reset;
    logic             done;
    logic             pass;
    logic             timeout;
    logic [XLEN-1:0]  halt_pc;
    logic [CNT_W-1:0] cycle_count;
`ifdef RUN_CTRL_INSTRET_EN
    logic [CNT_W-1:0] instret;
`endif

    modport master (
        output pc, halt_req, commit,
        input  core_reset, done, pass, timeout, halt_pc, cycle_count
`ifdef RUN_CTRL_INSTRET_EN
        , input instret
`endif
    );

    modport slave (
        input  pc, halt_req, commit,
        output core_reset, done, pass, timeout, halt_pc, cycle_count
`ifdef RUN_CTRL_INSTRET_EN
        , output instret
`endif
    );
endinterface

// File: rtl/cpu_run_ctrl.sv
// Run controller: holds the core in reset, runs it, ends on halt / PC stall / cycle budget.
// Optional retired-instruction counter enabled by RUN_CTRL_INSTRET_EN.
module cpu_run_ctrl #(
    parameter int unsigned XLEN         = 32,
    parameter int unsigned CNT_W        = 32,
    parameter int unsigned RESET_CYCLES = 1,
    parameter int unsigned MAX_CYCLES   = 14,
    parameter int unsigned STALL_CYCLES = 4
) (
    input logic         clk,
    input logic         reset,
    cpu_run_ctrl_if.slave bus
);
    typedef enum logic [1:0] {StHold, StRun, StPass, StFail} state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] cycle_cnt_q, cycle_cnt_d;
    logic [XLEN-1:0]  pc_prev_q, pc_prev_d;
    logic             pc_vld_q, pc_vld_d;
    logic             core_reset_q, core_reset_d;
    logic             done_q, done_d;
    logic             pass_q, pass_d;
    logic             timeout_q, timeout_d;
    logic [XLEN-1:0]  halt_pc_q, halt_pc_d;
`ifdef RUN_CTRL_INSTRET_EN
    logic [CNT_W-1:0] instret_q, instret_d;
`else
    logic             unused_commit;
    assign unused_commit = bus.commit;
`endif

    logic pc_match;
    logic stall_hit;

    assign pc_match  = pc_vld_q && (bus.pc == pc_prev_q);
    assign stall_hit = (STALL_CYCLES != 0) && pc_match &&
                       ((stall_cnt_q + CNT_W'(1)) == CNT_W'(STALL_CYCLES));

    always_comb begin
        state_d      = state_q;
        hold_cnt_d   = hold_cnt_q;
        stall_cnt_d  = stall_cnt_q;
        cycle_cnt_d  = cycle_cnt_q;
        pc_prev_d    = pc_prev_q;
        pc_vld_d     = pc_vld_q;
        core_reset_d = core_reset_q;
        done_d       = done_q;
        pass_d       = pass_q;
        timeout_d    = timeout_q;
        halt_pc_d    = halt_pc_q;
`ifdef RUN_CTRL_INSTRET_EN
        instret_d    = instret_q;
`endif
        case (state_q)
            StHold: begin
                hold_cnt_d = hold_cnt_q + CNT_W'(1);
                if (hold_cnt_q == CNT_W'(RESET_CYCLES - 1)) begin
                    state_d      = StRun;
                    core_reset_d = 1'b0;
                end
            end
            StRun: begin
                cycle_cnt_d = cycle_cnt_q + CNT_W'(1);
                pc_prev_d   = bus.pc;
                pc_vld_d    = 1'b1;
                stall_cnt_d = pc_match ? stall_cnt_q + CNT_W'(1) : '0;
`ifdef RUN_CTRL_INSTRET_EN
                if (bus.commit) instret_d = instret_q + CNT_W'(1);
`endif
                // halt_req and stall outrank the budget, even on the last cycle
                if (bus.halt_req || stall_hit) begin
                    state_d = StPass;
                    pass_d  = 1'b1;
                end else if (cycle_cnt_q == CNT_W'(MAX_CYCLES - 1)) begin
                    state_d   = StFail;
                    timeout_d = 1'b1;
                end
                if (state_d != StRun) begin
                    halt_pc_d    = bus.pc;
                    done_d       = 1'b1;
                    core_reset_d = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= StHold;
            hold_cnt_q   <= '0;
            stall_cnt_q  <= '0;
            cycle_cnt_q  <= '0;
            pc_prev_q    <= '0;
            pc_vld_q     <= 1'b0;
            core_reset_q <= 1'b1;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
            timeout_q    <= 1'b0;
            halt_pc_q    <= '0;
`ifdef RUN_CTRL_INSTRET_EN
            instret_q    <= '0;
`endif
        end else begin
            state_q      <= state_d;
            hold_cnt_q   <= hold_cnt_d;
            stall_cnt_q  <= stall_cnt_d;
            cycle_cnt_q  <= cycle_cnt_d;
            pc_prev_q    <= pc_prev_d;
            pc_vld_q     <= pc_vld_d;
            core_reset_q <= core_reset_d;
            done_q       <= done_d;
            pass_q       <= pass_d;
            timeout_q    <= timeout_d;
            halt_pc_q    <= halt_pc_d;
`ifdef RUN_CTRL_INSTRET_EN
            instret_q    <= instret_d;
`endif
        end
    end

    assign bus.core_reset  = core_reset_q;
    assign bus.done        = done_q;
    assign bus.pass        = pass_q;
    assign bus.timeout     = timeout_q;
    assign bus.halt_pc     = halt_pc_q;
    assign bus.cycle_count = cycle_cnt_q;
`ifdef RUN_CTRL_INSTRET_EN
    assign bus.instret     = instret_q;
`endif
endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Bench for cpu_run_ctrl: directed scenarios plus random runs against a trace-level model.
module tb_cpu_run_ctrl;
    localparam int unsigned XLEN         = 32;
    localparam int unsigned CNT_W        = 32;
    localparam int unsigned RESET_CYCLES = 1;
    localparam int unsigned MAX_CYCLES   = 14;
    localparam int unsigned STALL_CYCLES = 4;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    cpu_run_ctrl_if #(.XLEN(XLEN), .CNT_W(CNT_W)) bus ();

    cpu_run_ctrl #(
        .XLEN        (XLEN),
        .CNT_W       (CNT_W),
        .RESET_CYCLES(RESET_CYCLES),
        .MAX_CYCLES  (MAX_CYCLES),
        .STALL_CYCLES(STALL_CYCLES)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, ".core_reset"}, 64'(bus.core_reset), 64'd1);
        check({tag, ".done"}, 64'(bus.done), 64'd0);
        check({tag, ".pass"}, 64'(bus.pass), 64'd0);
        check({tag, ".timeout"}, 64'(bus.timeout), 64'd0);
        check({tag, ".halt_pc"}, 64'(bus.halt_pc), 64'd0);
        check({tag, ".cycle_count"}, 64'(bus.cycle_count), 64'd0);
`ifdef RUN_CTRL_INSTRET_EN
        check({tag, ".instret"}, 64'(bus.instret), 64'd0);
`endif
    endtask

    task automatic drive_random();
        bus.pc       = $urandom();
        bus.halt_req = 1'($urandom_range(0, 1));
        bus.commit   = 1'($urandom_range(0, 1));
    endtask

    // mode 0 random, 1 pc+=4, 2 halt on cycle 5 at 0x10, 3 pc=0x20 from cycle 3, 4 halt on cycle 14
    task automatic do_run(input int mode, input int rst_at);
        logic [XLEN-1:0] pcs     [1:MAX_CYCLES];
        bit              halts   [1:MAX_CYCLES];
        bit              commits [1:MAX_CYCLES];
        int              fin;
        bit              exp_pass;
        int              exp_ret;
        bit              stall;

        for (int k = 1; k <= int'(MAX_CYCLES); k++) begin
            commits[k] = bit'($urandom_range(0, 1));
            pcs[k]     = XLEN'(32'h100 + 4 * k);
            halts[k]   = 1'b0;
            case (mode)
                0: begin
                    if (k > 1 && $urandom_range(0, 2) != 0) pcs[k] = pcs[k-1];
                    else pcs[k] = $urandom() & ~32'h3;
                    halts[k] = ($urandom_range(0, 15) == 0);
                end
                2: begin
                    if (k == 5) begin
                        pcs[k]   = XLEN'(32'h10);
                        halts[k] = 1'b1;
                    end
                end
                3: if (k >= 3) pcs[k] = XLEN'(32'h20);
                4: halts[k] = (k == int'(MAX_CYCLES));
                default: ;
            endcase
        end

        // Run ends at the first halt, or once the PC has sat still for STALL_CYCLES
        // consecutive comparisons, or at the budget.
        fin      = int'(MAX_CYCLES);
        exp_pass = 1'b0;
        for (int k = 1; k <= int'(MAX_CYCLES); k++) begin
            stall = (STALL_CYCLES != 0) && (k > int'(STALL_CYCLES));
            for (int j = 1; j <= int'(STALL_CYCLES); j++)
                if (k - j >= 1 && pcs[k-j] != pcs[k]) stall = 1'b0;
            if (halts[k] || stall) begin
                fin      = k;
                exp_pass = 1'b1;
                break;
            end
        end
        exp_ret = 0;
        for (int k = 1; k <= fin; k++) exp_ret += int'(commits[k]);

        reset = 1'b0;
        drive_random();
        @(negedge clk);
        check_reset_state("reset");
        reset = 1'b1;
        @(negedge clk);
        check("hold_release.core_reset", 64'(bus.core_reset), 64'd0);
        check("hold_release.cycle_count", 64'(bus.cycle_count), 64'd0);

        for (int k = 1; k <= fin + 3; k++) begin
            if (k <= fin) begin
                bus.pc       = pcs[k];
                bus.halt_req = halts[k];
                bus.commit   = commits[k];
            end else begin
                drive_random();
            end
            if (k == rst_at) reset = 1'b0;
            @(negedge clk);
            if (k == rst_at) begin
                check_reset_state("midrun_reset");
                reset = 1'b1;
                return;
            end
            if (k < fin) begin
                check("run.done", 64'(bus.done), 64'd0);
                check("run.core_reset", 64'(bus.core_reset), 64'd0);
                check("run.cycle_count", 64'(bus.cycle_count), 64'(k));
            end else begin
                check("end.done", 64'(bus.done), 64'd1);
                check("end.pass", 64'(bus.pass), 64'(exp_pass));
                check("end.timeout", 64'(bus.timeout), 64'(!exp_pass));
                check("end.halt_pc", 64'(bus.halt_pc), 64'(pcs[fin]));
                check("end.cycle_count", 64'(bus.cycle_count), 64'(fin));
                check("end.core_reset", 64'(bus.core_reset), 64'd1);
`ifdef RUN_CTRL_INSTRET_EN
                check("end.instret", 64'(bus.instret), 64'(exp_ret));
`endif
            end
        end
    endtask

    initial begin
        bus.pc       = '0;
        bus.halt_req = 1'b0;
        bus.commit   = 1'b0;
        repeat (2) @(negedge clk);
        do_run(1, 0);
        do_run(2, 0);
        do_run(3, 0);
        do_run(4, 0);
        do_run(1, 8);
        do_run(1, 0);
        for (int r = 0; r < 40; r++) do_run(0, (r % 7 == 3) ? $urandom_range(1, 6) : 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
